// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage arithmetic unit.
//   - ALU_* operation codes as delivered by the ALU control decoder
//   - mul_state_e: iterative multiplier state encoding
//   - MUL_ITERS: number of shift-add iterations for a full-width product
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_XOR  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_ADDI = 4'd6;
  localparam logic [3:0] ALU_SRAI = 4'd7;
  localparam logic [3:0] ALU_LS   = 4'd8;
  localparam logic [3:0] ALU_BEQ  = 4'd9;

  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/iter_mul.sv
// iter_mul: iterative shift-add multiplier, low DATA_W bits of a_i * b_i.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; operands are sampled on the start edge
// BUSY  | one shift-add step per cycle, MUL_ITERS cycles in total
// DONE  | product_o valid for exactly one cycle, then back to IDLE
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        begin a multiply (ignored unless ready_o)
//   flush_i        abort: blocks a start in IDLE, drops the product in BUSY
//   a_i, b_i       operands
//   ready_o        IDLE and able to accept a start
//   busy_o         in BUSY
//   done_o         in DONE, product_o valid
//   product_o      accumulator
module iter_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(MUL_ITERS + 1);

  mul_state_e        state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  // The ID/EX register may still present the finished mul for one cycle
  // after DONE; this blocks it from being started a second time.
  logic              post_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      post_done_q <= 1'b0;
    end else begin
      post_done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start_i && !flush_i && !post_done_q) begin
            state_q  <= BUSY;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(MUL_ITERS);
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o   = (state_q == IDLE) && !post_done_q;
  assign busy_o    = (state_q == BUSY);
  assign done_o    = (state_q == DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage arithmetic unit of the RV32 core.
// Single-cycle ops are combinational; mul runs on iter_mul and holds the
// pipeline with stall_o until the product is presented.
//
// Build option: ALU_FAST_MUL_EN -- mul becomes a combinational multiply,
// iter_mul is not instantiated and stall_o is tied low.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i        EX holds a live instruction
//   ALUCtrl_i      operation code (alu_pkg::ALU_*)
//   data1_i        operand A (rs1)
//   data2_i        operand B (rs2 / imm); shift amount is data2_i[4:0]
//   flush_i        abort an in-flight or issuing multiply
//   result_o       operation result
//   zero_o         result_o == 0
//   valid_o        result_o valid this cycle
//   stall_o        freeze PC, IF/ID and ID/EX
module ex_alu_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              stall_o
);
  import alu_pkg::*;

  logic [4:0]        shamt;
  logic [DATA_W-1:0] op_res;
  logic              is_mul;

  assign shamt  = data2_i[4:0];
  assign is_mul = (ALUCtrl_i == ALU_MUL);

  always_comb begin
    op_res = '0;
    case (ALUCtrl_i)
      ALU_AND:                  op_res = data1_i & data2_i;
      ALU_XOR:                  op_res = data1_i ^ data2_i;
      ALU_SLL:                  op_res = data1_i << shamt;
      ALU_ADD, ALU_ADDI, ALU_LS: op_res = data1_i + data2_i;
      ALU_SUB, ALU_BEQ:         op_res = data1_i - data2_i;
      ALU_SRAI:                 op_res = $signed(data1_i) >>> shamt;
`ifdef ALU_FAST_MUL_EN
      ALU_MUL:                  op_res = data1_i * data2_i;
`endif
      default:                  op_res = '0;
    endcase
  end

`ifdef ALU_FAST_MUL_EN

  always_comb begin
    result_o = rst_i ? '0 : op_res;
    valid_o  = !rst_i && valid_i;
    stall_o  = 1'b0;
  end

`else

  logic              mul_start;
  logic              mul_ready;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  // Flush in the issue cycle wins: no start and therefore no stall.
  assign mul_start = valid_i && is_mul && !flush_i && mul_ready;

  iter_mul #(.DATA_W(DATA_W)) u_iter_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .flush_i   (flush_i),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .ready_o   (mul_ready),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    result_o = '0;
    valid_o  = 1'b0;
    stall_o  = 1'b0;
    if (!rst_i) begin
      if (mul_done) begin
        result_o = mul_prod;
        valid_o  = 1'b1;
      end else begin
        result_o = op_res;
        // A mul only produces a result through DONE.
        valid_o  = valid_i && !is_mul && !mul_busy;
        stall_o  = mul_busy || mul_start;
      end
    end
  end

`endif

  assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        valid_o;
  logic        stall_o;

  int n_total = 0;
  int n_pass  = 0;

  ex_alu_unit #(.DATA_W(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .stall_o   (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: operation semantics from plain arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] ones;
    s = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    case (op)
      0:       return a & b;
      1:       return a ^ b;
      2:       return a << s;
      3, 6, 8: return a + b;
      4, 9:    return a - b;
      5:       return a * b;
      7:       return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input int op, input logic [31:0] a, input logic [31:0] b);
    valid_i   = v;
    ALUCtrl_i = 4'(op);
    data1_i   = a;
    data2_i   = b;
  endtask

  // Drive one single-cycle op and check it at the falling edge.
  task automatic single(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    drive(1'b1, op, a, b);
    e = ref_alu(op, a, b);
    @(negedge clk_i);
    chk({tag, "_res"}, result_o, e);
    chk({tag, "_zero"}, 32'(zero_o), 32'(e == 32'h0));
    chk({tag, "_valid"}, 32'(valid_o), 32'h1);
    chk({tag, "_stall"}, 32'(stall_o), 32'h0);
    step();
  endtask

`ifndef ALU_FAST_MUL_EN
  // Issue a mul, measure stall length and product, then confirm the held
  // instruction is not re-issued in the following cycle.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int stalls = 0;
    bit found = 0;
    logic [31:0] got = 32'h0;
    drive(1'b1, 5, a, b);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) begin
        got = result_o;
        found = 1;
        break;
      end
      if (stall_o) stalls++;
      step();
      // Operand changes during BUSY must be ignored.
      data1_i = $urandom;
      data2_i = $urandom;
    end
    chk({tag, "_done_seen"}, 32'(found), 32'h1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
    chk({tag, "_product"}, got, a * b);
    step();
    data1_i = a;
    data2_i = b;
    @(negedge clk_i);
    chk({tag, "_no_restall"}, 32'(stall_o), 32'h0);
    chk({tag, "_valid_pulse"}, 32'(valid_o), 32'h0);
    step();
  endtask
`endif

  initial begin
    int op;
    logic [31:0] a, b;
    rst_i = 1'b1;
    flush_i = 1'b0;
    drive(1'b1, 3, 32'd5, 32'd7);
    step();
    @(negedge clk_i);
    chk("rst_result", result_o, 32'h0);
    chk("rst_zero", 32'(zero_o), 32'h1);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    step();
    rst_i = 1'b0;

    single("add", 3, 32'd5, 32'd7);
    single("beq", 9, 32'd3, 32'd3);
    single("srai", 7, 32'h8000_0000, 32'd4);
    single("sll", 2, 32'h1, 32'd31);
    single("unused12", 12, 32'hDEAD_BEEF, 32'h1234_5678);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
`ifndef ALU_FAST_MUL_EN
      if (op == 5) op = 3;
`endif
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      if (i % 7 == 3) begin
        drive(1'b0, op, a, b);
        @(negedge clk_i);
        chk("idle_valid", 32'(valid_o), 32'h0);
        chk("idle_stall", 32'(stall_o), 32'h0);
        step();
      end else begin
        single("rand", op, a, b);
      end
    end

`ifdef ALU_FAST_MUL_EN
    single("fastmul", 5, 32'd7, 32'd6);
    chk("fastmul_ref", ref_alu(5, 32'd7, 32'd6), 32'd42);
    for (int i = 0; i < 8; i++) single("fastmul_rand", 5, $urandom, $urandom);
`else
    do_mul("mul_neg", 32'd3, 32'hFFFF_FFFF);

    // Flush at BUSY cycle 10.
    drive(1'b1, 5, 32'h1234_5678, 32'h10);
    begin
      int vseen = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        @(negedge clk_i);
        if (valid_o) vseen++;
      end
      chk("flush_busy_stall", 32'(stall_o), 32'h1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      drive(1'b1, 3, 32'd1, 32'd1);
      @(negedge clk_i);
      chk("flush_no_valid_busy", 32'(vseen), 32'h0);
      chk("flush_stall_drop", 32'(stall_o), 32'h0);
      chk("flush_add_res", result_o, 32'd2);
      chk("flush_add_valid", 32'(valid_o), 32'h1);
      step();
    end

    // Reset at BUSY cycle 20.
    drive(1'b1, 5, $urandom, $urandom);
    for (int c = 0; c < 20; c++) step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_busy_stall", 32'(stall_o), 32'h0);
    step();
    rst_i = 1'b0;
    drive(1'b0, 3, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("post_rst_result", result_o, 32'h0);
    chk("post_rst_zero", 32'(zero_o), 32'h1);
    chk("post_rst_valid", 32'(valid_o), 32'h0);
    chk("post_rst_stall", 32'(stall_o), 32'h0);
    step();
    do_mul("mul_7x6", 32'd7, 32'd6);

    // Flush together with mul issue: nothing starts.
    drive(1'b1, 5, 32'd9, 32'd9);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_issue_stall", 32'(stall_o), 32'h0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 3, 32'd0, 32'd0);
    @(negedge clk_i);
    chk("flush_issue_nostart", 32'(stall_o), 32'h0);
    step();

    for (int i = 0; i < 3; i++) do_mul("mul_rand", $urandom, $urandom);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
